// File: rtl/rx_nrzi_unstuff_shift.sv
// rtl/rx_nrzi_unstuff_shift.sv - USB receive NRZI decode, bit unstuffing and LSB-first byte assembly
module rx_nrzi_unstuff_shift #(
  parameter int DATA_W    = 8,
  parameter int STUFF_RUN = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SR_shift,
  input  logic              rcving,
  input  logic              d_plus,
  input  logic              d_minus,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              eop,
  output logic              stuff_err
);

  localparam int BCW = $clog2(DATA_W);
  localparam int OCW = $clog2(STUFF_RUN + 1);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);
  localparam logic [OCW-1:0] ONES_STUFF = OCW'(STUFF_RUN);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    SE0_1,
    EOP_WAIT,
    ERR
  } state_t;

  state_t            state_q;
  logic              prev_dp_q;
  logic [OCW-1:0]    ones_cnt_q;
  logic [BCW-1:0]    bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] rx_byte_q;
  logic              byte_valid_q;
  logic              eop_q;
  logic              stuff_err_q;

  logic              line_se0;
  logic              line_j;
  logic              dec_bit;
  logic              decode_en;
  logic [DATA_W-1:0] shift_d;

  // Line classification, NRZI decode and the word as it looks after shifting this bit in
  always_comb begin
    line_se0  = !d_plus && !d_minus;
    line_j    = d_plus && !d_minus;
    dec_bit   = (d_plus == prev_dp_q);
    shift_d   = {dec_bit, shift_q[DATA_W-1:1]};
    // A non-SE0 sample right after a lone SE0 is a glitch and still carries data
    decode_en = SR_shift && !line_se0 && ((state_q == RECV) || (state_q == SE0_1));
  end

  // Receive FSM with registered pulse outputs; decode section may override the state move
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_dp_q    <= 1'b1;
      ones_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      eop_q        <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      eop_q        <= 1'b0;
      stuff_err_q  <= 1'b0;
      if (!rcving) begin
        // Closing the receive window drops any partial word silently; rx_byte keeps the last word
        state_q    <= IDLE;
        prev_dp_q  <= 1'b1;
        ones_cnt_q <= '0;
        bit_cnt_q  <= '0;
        shift_q    <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= RECV;
          RECV: begin
            if (SR_shift && line_se0) begin
              state_q <= SE0_1;
            end
          end
          SE0_1: begin
            if (SR_shift) begin
              if (line_se0) begin
                eop_q      <= 1'b1;
                bit_cnt_q  <= '0;
                ones_cnt_q <= '0;
                shift_q    <= '0;
                prev_dp_q  <= 1'b1;
                state_q    <= EOP_WAIT;
              end else begin
                state_q <= RECV;
              end
            end
          end
          EOP_WAIT: begin
            if (SR_shift && line_j) begin
              state_q <= RECV;
            end
          end
          ERR: begin
            if (SR_shift && line_se0) begin
              state_q <= SE0_1;
            end
          end
          default: state_q <= IDLE;
        endcase

        if (decode_en) begin
          prev_dp_q <= d_plus;
          if (ones_cnt_q == ONES_STUFF) begin
            ones_cnt_q <= '0;
            if (dec_bit) begin
              // A seventh 1 means the transmitter failed to stuff
              stuff_err_q <= 1'b1;
              shift_q     <= '0;
              bit_cnt_q   <= '0;
              state_q     <= ERR;
            end
          end else begin
            shift_q    <= shift_d;
            ones_cnt_q <= dec_bit ? ones_cnt_q + 1'b1 : '0;
            if (bit_cnt_q == BIT_LAST) begin
              rx_byte_q    <= shift_d;
              byte_valid_q <= 1'b1;
              bit_cnt_q    <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
      end
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign eop        = eop_q;
  assign stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_rx_nrzi_unstuff_shift.sv
// tb/tb_rx_nrzi_unstuff_shift.sv - directed vector bench for rx_nrzi_unstuff_shift
module tb_rx_nrzi_unstuff_shift;

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LS = 2'b00;

  typedef struct {
    logic [1:0] line;
    logic       bv;
    logic       eopx;
    logic       errx;
    logic [7:0] data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SR_shift = 1'b0;
  logic       rcving = 1'b0;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       eop;
  logic       stuff_err;

  int         n_vec = 0;
  int         n_fail = 0;
  logic [7:0] exp_rx = 8'h00;
  vec_t       vecs[$];

  rx_nrzi_unstuff_shift #(.DATA_W(8), .STUFF_RUN(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .SR_shift  (SR_shift),
    .rcving    (rcving),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .eop       (eop),
    .stuff_err (stuff_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] line, input logic bv, input logic e, input logic s,
                     input logic [7:0] data);
    vec_t v;
    v.line = line; v.bv = bv; v.eopx = e; v.errx = s; v.data = data;
    vecs.push_back(v);
  endtask

  // One strobe, check pulses and rx_byte, then one idle cycle where all pulses must be low
  task automatic strobe(input logic [1:0] line, input logic bv, input logic e, input logic s,
                        input logic [7:0] data, input string tag);
    @(negedge clk);
    d_plus = line[1]; d_minus = line[0]; SR_shift = 1'b1;
    @(posedge clk); #1;
    SR_shift = 1'b0;
    if (bv) exp_rx = data;
    chk({tag, " byte_valid"}, {7'b0, byte_valid}, {7'b0, bv});
    chk({tag, " eop"}, {7'b0, eop}, {7'b0, e});
    chk({tag, " stuff_err"}, {7'b0, stuff_err}, {7'b0, s});
    chk({tag, " rx_byte"}, rx_byte, exp_rx);
    @(posedge clk); #1;
    chk({tag, " pulse_clear"}, {5'b0, byte_valid, eop, stuff_err}, 8'h00);
  endtask

  task automatic sync_byte(input string tag);
    logic [1:0] s [8];
    s = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};
    for (int i = 0; i < 8; i++)
      strobe(s[i], i == 7, 1'b0, 1'b0, 8'h80, $sformatf("%s_%0d", tag, i));
  endtask

  initial begin
    // sync 0x80 after reset
    add(LK,0,0,0,0); add(LJ,0,0,0,0); add(LK,0,0,0,0); add(LJ,0,0,0,0);
    add(LK,0,0,0,0); add(LJ,0,0,0,0); add(LK,0,0,0,0); add(LK,1,0,0,8'h80);
    // three data bits, then SE0 SE0 J
    add(LK,0,0,0,0); add(LJ,0,0,0,0); add(LJ,0,0,0,0);
    add(LS,0,0,0,0); add(LS,0,1,0,0); add(LJ,0,0,0,0);
    // 0xFF with stuffed 0 after the sixth one, then 0x01
    for (int i = 0; i < 6; i++) add(LJ,0,0,0,0);
    add(LK,0,0,0,0); add(LK,0,0,0,0); add(LK,1,0,0,8'hFF);
    add(LK,0,0,0,0); add(LJ,0,0,0,0); add(LK,0,0,0,0); add(LJ,0,0,0,0);
    add(LK,0,0,0,0); add(LJ,0,0,0,0); add(LK,0,0,0,0); add(LJ,1,0,0,8'h01);
    // seven ones -> stuff error, data ignored until SE0 SE0 J
    for (int i = 0; i < 6; i++) add(LJ,0,0,0,0);
    add(LJ,0,0,1,0);
    add(LK,0,0,0,0); add(LK,0,0,0,0); add(LJ,0,0,0,0);
    add(LS,0,0,0,0); add(LS,0,1,0,0); add(LJ,0,0,0,0);
    // 0x35 with a lone SE0 glitch after the third bit
    add(LJ,0,0,0,0); add(LK,0,0,0,0); add(LK,0,0,0,0); add(LS,0,0,0,0);
    add(LJ,0,0,0,0); add(LJ,0,0,0,0); add(LJ,0,0,0,0); add(LK,0,0,0,0);
    add(LJ,1,0,0,8'h35);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset rx_byte", rx_byte, 8'h00);
    chk("reset pulses", {5'b0, byte_valid, eop, stuff_err}, 8'h00);
    @(negedge clk);
    rst = 1'b1; rcving = 1'b1;

    foreach (vecs[i])
      strobe(vecs[i].line, vecs[i].bv, vecs[i].eopx, vecs[i].errx, vecs[i].data,
             $sformatf("vec%0d", i));

    // rcving drop mid-byte, re-entry with a strobe on the entry cycle
    strobe(LK,0,0,0,0,"drop_a"); strobe(LJ,0,0,0,0,"drop_b"); strobe(LK,0,0,0,0,"drop_c");
    @(negedge clk);
    rcving = 1'b0; SR_shift = 1'b1; d_plus = 1'b0; d_minus = 1'b1;
    @(posedge clk); #1;
    SR_shift = 1'b0;
    chk("drop pulses", {5'b0, byte_valid, eop, stuff_err}, 8'h00);
    chk("drop rx_byte", rx_byte, exp_rx);
    @(negedge clk);
    rcving = 1'b1; SR_shift = 1'b1;
    @(posedge clk); #1;
    SR_shift = 1'b0;
    chk("entry pulses", {5'b0, byte_valid, eop, stuff_err}, 8'h00);
    sync_byte("resync");

    // reset held for three strobed cycles mid-byte
    strobe(LK,0,0,0,0,"prerst_a"); strobe(LJ,0,0,0,0,"prerst_b"); strobe(LK,0,0,0,0,"prerst_c");
    exp_rx = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0; SR_shift = 1'b1;
      d_plus = i[0]; d_minus = ~i[0];
      @(posedge clk); #1;
      chk($sformatf("rst%0d rx_byte", i), rx_byte, 8'h00);
      chk($sformatf("rst%0d pulses", i), {5'b0, byte_valid, eop, stuff_err}, 8'h00);
    end
    @(negedge clk);
    rst = 1'b1; SR_shift = 1'b0;
    sync_byte("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
